diode_bias_ctrl: RTL and testbench

DIODE_BIAS_CTRL -- requirements
Module: diode_bias_ctrl

---
 rtl/diode_bias_ctrl.sv | 132 +++++++++++++
 tb/tb_diode_bias_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/diode_bias_ctrl.sv
// diode_bias_ctrl: ramps each diode's bias over SPI until filtered noise marks breakdown, then backs off
module diode_bias_ctrl #(
  parameter int NCH = 2,
  parameter int VW = 8,
  parameter int STEP = 1,
  parameter int BACKOFF = 4,
  parameter int DWELL = 16,
  parameter int FILT = 3,
  parameter int CLK_DIV = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [NCH-1:0] noise_valid,
  output logic           spi_mosi,
  output logic           spi_clk,
  output logic           spi_ss,
  output logic           busy,
  output logic           done,
  output logic [NCH-1:0] ch_fail,
  output logic [VW-1:0]  debug_voltage,
  output logic [2:0]     debug_state
);
  localparam int FW = 4 + VW;
  localparam int BW = $clog2(FW + 1);
  localparam int DV = $clog2(CLK_DIV + 1);
  localparam int DW = $clog2(DWELL + 1);
  localparam int HW = $clog2(FILT + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_DWELL, S_BACKOFF, S_NEXT, S_DONE} state_t;
  state_t          state;
  logic [3:0]      ch;
  logic [VW-1:0]   code;
  logic [FW-1:0]   sh;
  logic [BW-1:0]   bcnt;
  logic [DV-1:0]   div;
  logic [DW-1:0]   dcnt;
  logic [HW-1:0]   hcnt;
  logic [NCH-1:0]  s1, s2;
  logic            ramp, hit;
  logic [VW:0]     sum;
  logic [VW-1:0]   back;
  assign hit = |(s2 & (NCH'(1) << ch));
  assign sum = {1'b0, code} + (VW+1)'(STEP);
  assign back = (code >= VW'(BACKOFF)) ? code - VW'(BACKOFF) : '0;
  assign debug_voltage = code;
  assign debug_state = state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ch <= '0;
      code <= '0;
      sh <= '0;
      bcnt <= '0;
      div <= '0;
      dcnt <= '0;
      hcnt <= '0;
      s1 <= '0;
      s2 <= '0;
      ramp <= 1'b0;
      spi_ss <= 1'b1;
      spi_clk <= 1'b0;
      spi_mosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      ch_fail <= '0;
    end else begin
      s1 <= noise_valid;
      s2 <= s1;
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          ch_fail <= '0;
          ch <= '0;
          code <= '0;
          busy <= 1'b1;
          ramp <= 1'b1;
          state <= S_LOAD;
        end
        S_LOAD: begin
          sh <= {ch, code};
          spi_mosi <= ch[3];
          spi_ss <= 1'b0;
          bcnt <= '0;
          div <= '0;
          state <= S_SEND;
        end
        S_SEND: if (bcnt == BW'(FW)) begin
          spi_ss <= 1'b1;
          spi_mosi <= 1'b0;
          dcnt <= '0;
          hcnt <= '0;
          state <= ramp ? S_DWELL : S_NEXT;
        end else if (div == DV'(CLK_DIV - 1)) begin
          div <= '0;
          spi_clk <= ~spi_clk;
          if (spi_clk) begin
            sh <= sh << 1;
            spi_mosi <= sh[FW-2];
            bcnt <= bcnt + 1'b1;
          end
        end else div <= div + 1'b1;
        S_DWELL: begin
          hcnt <= hit ? hcnt + 1'b1 : '0;
          dcnt <= dcnt + 1'b1;
          if (hit && hcnt == HW'(FILT - 1)) begin
            code <= back;
            ramp <= 1'b0;
            state <= S_BACKOFF;
          end else if (dcnt == DW'(DWELL - 1)) begin
            ramp <= ~sum[VW];
            code <= sum[VW] ? '0 : sum[VW-1:0];
            if (sum[VW]) ch_fail <= ch_fail | (NCH'(1) << ch);
            state <= S_LOAD;
          end
        end
        S_BACKOFF: state <= S_LOAD;
        S_NEXT: if (32'(ch) < NCH - 1) begin
          ch <= ch + 4'd1;
          code <= '0;
          ramp <= 1'b1;
          state <= S_LOAD;
        end else state <= S_DONE;
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_diode_bias_ctrl.sv
// tb_diode_bias_ctrl: directed checks of ramp, breakdown backoff, glitch rejection, saturation, abort and start-while-busy
module tb_diode_bias_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] noise_valid = 2'b00;
  logic spi_mosi, spi_clk, spi_ss, busy, done;
  logic [1:0] ch_fail;
  logic [7:0] debug_voltage;
  logic [2:0] debug_state;
  int checks = 0;
  int errors = 0;
  logic [11:0] fq[$];
  logic [11:0] cap = '0;
  int nbits = 0;
  int bo_cnt = 0;
  logic psck = 1'b0;
  logic pss = 1'b1;
  diode_bias_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .noise_valid(noise_valid),
    .spi_mosi(spi_mosi), .spi_clk(spi_clk), .spi_ss(spi_ss), .busy(busy), .done(done),
    .ch_fail(ch_fail), .debug_voltage(debug_voltage), .debug_state(debug_state)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (spi_ss) begin
      if (!pss && nbits == 12) fq.push_back(cap);
      nbits = 0;
    end else if (spi_clk && !psck) begin
      cap = {cap[10:0], spi_mosi};
      nbits++;
    end
    if (debug_state == 3'd4) bo_cnt++;
    psck = spi_clk;
    pss = spi_ss;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic get_frame(input string tag, output logic [11:0] f);
    int n = 0;
    while (fq.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (fq.size() == 0) begin
      chk({tag, " timeout"}, fq.size(), 1);
      f = '0;
    end else f = fq.pop_front();
  endtask
  task automatic wait_state(input string tag, input logic [2:0] st, input logic [7:0] v);
    int n = 0;
    while (!(debug_state == st && debug_voltage == v) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {debug_state, debug_voltage}, {st, v});
  endtask
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    logic [11:0] f;
    int n, e, bo0;
    logic p;
    repeat (2) @(negedge clk);
    chk("rst_ss", spi_ss, 1);
    chk("rst_sclk", spi_clk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", ch_fail, 0);
    chk("rst_volt", debug_voltage, 0);
    chk("rst_state", debug_state, 0);
    pulse_start;
    chk("rst_dom_busy", busy, 0);
    chk("rst_dom_state", debug_state, 0);
    reset = 1'b0;
    @(negedge clk);
    pulse_start;
    chk("start_busy", busy, 1);
    chk("start_state", debug_state, 1);
    for (int i = 0; i < 10; i++) begin
      get_frame("ramp0", f);
      chk("ramp0", f, i);
    end
    n = 0;
    while (debug_voltage != 8'd10 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    noise_valid[0] = 1'b1;
    get_frame("bd_a", f);
    chk("bd_frame_0a", f, 12'h00A);
    get_frame("bd_b", f);
    chk("bd_backoff_006", f, 12'h006);
    noise_valid[0] = 1'b0;
    get_frame("ch1_start", f);
    chk("ch1_start_100", f, 12'h100);
    chk("bd_fail0", ch_fail[0], 0);
    for (int i = 1; i < 256; i++) begin
      get_frame("ramp1", f);
      chk("ramp1", f, 12'h100 | i);
    end
    get_frame("fail_frame", f);
    chk("fail_frame_100", f, 12'h100);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sat_done", done, 1);
    chk("sat_busy", busy, 0);
    chk("sat_fail", ch_fail, 2'b10);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("sat_idle", debug_state, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fq.delete();
    noise_valid[1] = 1'b1;
    pulse_start;
    for (int i = 0; i < 6; i++) begin
      get_frame("gl_ramp", f);
      chk("gl_ramp", f, i);
    end
    wait_state("gl_dwell5", 3'd3, 8'd5);
    bo0 = bo_cnt;
    repeat (3) begin
      noise_valid[0] = 1'b1;
      repeat (2) @(negedge clk);
      noise_valid[0] = 1'b0;
      repeat (2) @(negedge clk);
    end
    get_frame("gl_next", f);
    chk("gl_next_006", f, 12'h006);
    chk("gl_no_backoff", bo_cnt - bo0, 0);
    chk("gl_fail", ch_fail, 0);
    n = 0;
    while (spi_ss && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("ab_ss_low", spi_ss, 0);
    n = 0;
    e = 0;
    p = spi_clk;
    while (e < 5 && n < 500) begin
      @(negedge clk);
      if (spi_clk && !p) e++;
      p = spi_clk;
      n++;
    end
    chk("ab_5th_sclk", spi_clk, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("ab_ss", spi_ss, 1);
    chk("ab_sclk", spi_clk, 0);
    e = 0;
    p = spi_clk;
    repeat (8) begin
      @(negedge clk);
      if (spi_clk && !p) e++;
      p = spi_clk;
    end
    chk("ab_no_edges", e, 0);
    fq.delete();
    pulse_start;
    get_frame("ab_restart", f);
    chk("ab_restart_000", f, 12'h000);
    wait_state("sb_dwell0", 3'd3, 8'd0);
    pulse_start;
    chk("sb_state", debug_state, 3);
    chk("sb_volt", debug_voltage, 0);
    chk("sb_busy", busy, 1);
    get_frame("sb_next", f);
    chk("sb_next_001", f, 12'h001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
